bottling_line_ctrl: RTL and testbench
=====================================

# bottling_line_ctrl

Parametrised main controller for the automatic bottling line. It sequences each bottle through conveyor, filling, sealing, quality check and count/reject. It adds fill and seal watchdog timeouts, an internal batch counter that stops the line at the end of a batch, a consecutive-reject limit, and a latched fault state with a fault code. It sits above the conveyor motor, fill valve, sealer and QC station drivers and replaces the fixed-function main FSM.

## Interface
Parameters:
- FILL_TIMEOUT, 64: maximum cycles spent in FILL before a fault; must be ≥2.
- SEAL_TIMEOUT, 32: maximum cycles spent in SEAL before a fault; must be ≥2.
- BATCH_SIZE, 12: good bottles per batch; must be ≥1.
- MAX_REJECTS, 3: consecutive rejects that trigger a fault; must be ≥1.
- CNT_W, 8: width of the counters; 2^CNT_W must be > BATCH_SIZE.
- TMR_W, 8: timer width; must hold max(FILL_TIMEOUT, SEAL_TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operator run level.
- garrafa  in  1  bottle present at the fill position.
- sensor_de_nivel  in  1  fill level reached.
- ve_done  in  1  sealer finished.
- qc_pass  in  1  QC verdict: good.
- qc_fail  in  1  QC verdict: bad.
- fault_ack  in  1  operator fault acknowledge.
- motor, EV, pos_ve, controle_qualidade  out  1 each  conveyor, fill valve, seal position, QC enable.
- count  out  1  one-cycle good-bottle strobe.
- Desc_signal  out  1  one-cycle reject strobe.
- batch_done  out  1  one-cycle end-of-batch strobe.
- idle  out  1  controller is in IDLE.
- fault  out  1  controller is in FAULT.
- fault_code  out  2  fault cause: 00 none, 01 fill timeout, 10 seal timeout, 11 reject limit.
- good_count  out  CNT_W  good bottles in the current batch.
- reject_count  out  CNT_W  total rejects; saturates at all-ones.

## Operation
- States are IDLE, MOTOR, FILL, SEAL, QC, COUNT, REJECT and FAULT, held in a 3-bit state register.
- start_q is start registered each cycle. It resets to 1, so a start held high through reset does not run the line.
- IDLE → MOTOR on a start rising edge (start=1 while start_q=0). Otherwise IDLE holds.
- In MOTOR, FILL, SEAL and QC, start=0 → IDLE. This abort has highest priority over all other transitions.
- MOTOR → FILL when garrafa=1.
- FILL → SEAL when sensor_de_nivel=1. Else FILL → FAULT (code 01) when tmr==FILL_TIMEOUT-1. Else FILL holds.
- SEAL → QC when ve_done=1. Else SEAL → FAULT (code 10) when tmr==SEAL_TIMEOUT-1. Else SEAL holds.
- QC → COUNT when qc_pass=1; qc_pass wins if qc_pass and qc_fail are both high. QC → REJECT when only qc_fail=1. With neither, QC waits with no timeout.
- COUNT lasts one cycle and ignores start. rej_run clears to 0.
  - If good_count==BATCH_SIZE-1: batch_done=1, good_count wraps to 0, and the next state is IDLE. A new start rising edge is then needed to run the next batch.
  - Otherwise good_count increments and the next state is MOTOR.
- REJECT lasts one cycle and ignores start. reject_count increments (saturating) and rej_run increments.
  - If the incremented rej_run==MAX_REJECTS, the next state is FAULT with code 11.
  - Otherwise the next state is MOTOR.
- FAULT → IDLE when fault_ack=1 and start=0. While in FAULT, fault_code holds its value; it is cleared to 00 on the exit to IDLE. rej_run clears on exit from FAULT. good_count is kept.
- tmr clears to 0 on every state change and increments while the state holds. It is compared only in FILL and SEAL.
- Outputs are Moore decodes of the state: motor=MOTOR, EV=FILL, pos_ve=SEAL, controle_qualidade=QC, count=COUNT, Desc_signal=REJECT, idle=IDLE, fault=FAULT.
- batch_done = COUNT and good_count==BATCH_SIZE-1, using the pre-increment value.
- Illegal state encodings → IDLE on the next cycle.

## Timing
- Reset values: state IDLE, idle=1, and every other output 0. good_count, reject_count, rej_run, tmr and fault_code are 0; start_q is 1.
- All transitions take effect on the rising clk edge after the enabling inputs are sampled. Outputs change in the same cycle as the state.
- start rising edge sampled at edge k → motor=1 after edge k.
- Minimum bottle cycle (every input ready immediately): MOTOR, FILL, SEAL, QC and COUNT, one cycle each, for 5 cycles.
- FILL timeout: FILL lasts exactly FILL_TIMEOUT cycles, then FAULT. sensor_de_nivel=1 on the last FILL cycle still moves to SEAL. SEAL timeout works the same way with SEAL_TIMEOUT.
- The count, Desc_signal and batch_done strobes are exactly one cycle wide.
- Reset asserted mid-operation forces IDLE and zeroes all counters immediately, without waiting for a clock edge.

## Test plan
- Reset, then start 0→1, then garrafa, sensor_de_nivel, ve_done and qc_pass each pulsed on the first cycle of their state → states MOTOR, FILL, SEAL, QC, COUNT, MOTOR; good_count=1; count high for 1 cycle.
- BATCH_SIZE=3 with three good bottles → batch_done=1 on the third COUNT, good_count=0, state IDLE with start still high. It stays in IDLE until start goes 0 then 1.
- FILL_TIMEOUT=4 with sensor_de_nivel held 0 → EV high for 4 cycles, then fault=1 and fault_code=01. fault_ack=1 with start=0 → IDLE and fault_code=00.
- MAX_REJECTS=2 with two consecutive qc_fail bottles → Desc_signal pulses twice, reject_count=2, FAULT with code 11. A qc_pass between the two rejects instead → no fault.
- qc_pass and qc_fail both high in QC → COUNT, not REJECT. start dropped during SEAL → IDLE the next cycle with pos_ve=0.
- Reset asserted mid-FILL with good_count=2 → idle=1 and good_count=0 immediately, before the next clk edge. start held high through reset release → stays in IDLE.

Source files
------------

// File: rtl/bottling_line_ctrl.sv
// Main sequencer for the bottling line: conveyor, fill, seal, QC, count/reject, with watchdogs and batch control.
// Latency: one clk from sampled inputs to the new state; all outputs are registered-state decodes.
// Backpressure: none; each stage waits on its station handshake, FILL/SEAL are watchdog-bounded, QC waits forever.
module bottling_line_ctrl #(
    parameter int FILL_TIMEOUT = 64,
    parameter int SEAL_TIMEOUT = 32,
    parameter int BATCH_SIZE   = 12,
    parameter int MAX_REJECTS  = 3,
    parameter int CNT_W        = 8,
    parameter int TMR_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             garrafa,
    input  logic             sensor_de_nivel,
    input  logic             ve_done,
    input  logic             qc_pass,
    input  logic             qc_fail,
    input  logic             fault_ack,
    output logic             motor,
    output logic             EV,
    output logic             pos_ve,
    output logic             controle_qualidade,
    output logic             count,
    output logic             Desc_signal,
    output logic             batch_done,
    output logic             idle,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] reject_count
);

    // Compare constants sized to the registers they are compared against.
    localparam logic [TMR_W-1:0] FILL_LAST = TMR_W'(FILL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SEAL_LAST = TMR_W'(SEAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAST_GOOD = CNT_W'(BATCH_SIZE - 1);
    localparam logic [CNT_W-1:0] REJ_LIMIT = CNT_W'(MAX_REJECTS);

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_FILL = 2'b01;
    localparam logic [1:0] FC_SEAL = 2'b10;
    localparam logic [1:0] FC_REJ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOTOR  = 3'd1,
        S_FILL   = 3'd2,
        S_SEAL   = 3'd3,
        S_QC     = 3'd4,
        S_COUNT  = 3'd5,
        S_REJECT = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       fault_code_nxt;
    logic             start_q;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] rej_run;
    logic [CNT_W-1:0] rej_run_inc;

    logic start_rise;
    logic last_good;
    logic rej_limit;
    logic fill_expired;
    logic seal_expired;

    // start_q resets high so a start level held through reset is not seen as a rising edge.
    assign start_rise   = start & ~start_q;
    assign last_good    = (good_count == LAST_GOOD);
    assign rej_run_inc  = rej_run + 1'b1;
    assign rej_limit    = (rej_run_inc == REJ_LIMIT);
    assign fill_expired = (tmr == FILL_LAST);
    assign seal_expired = (tmr == SEAL_LAST);

    // Next-state and fault-cause selection; the operator abort wins over every other move in the running stages.
    always_comb begin
        state_nxt      = state;
        fault_code_nxt = fault_code;
        case (state)
            S_IDLE: begin
                if (start_rise) state_nxt = S_MOTOR;
            end
            S_MOTOR: begin
                if (!start)       state_nxt = S_IDLE;
                else if (garrafa) state_nxt = S_FILL;
            end
            S_FILL: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end else if (sensor_de_nivel) begin
                    state_nxt = S_SEAL;
                end else if (fill_expired) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_FILL;
                end
            end
            S_SEAL: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end else if (ve_done) begin
                    state_nxt = S_QC;
                end else if (seal_expired) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_SEAL;
                end
            end
            S_QC: begin
                // A good verdict wins if the station reports both at once.
                if (!start)       state_nxt = S_IDLE;
                else if (qc_pass) state_nxt = S_COUNT;
                else if (qc_fail) state_nxt = S_REJECT;
            end
            S_COUNT: begin
                state_nxt = last_good ? S_IDLE : S_MOTOR;
            end
            S_REJECT: begin
                if (rej_limit) begin
                    state_nxt      = S_FAULT;
                    fault_code_nxt = FC_REJ;
                end else begin
                    state_nxt = S_MOTOR;
                end
            end
            S_FAULT: begin
                if (fault_ack && !start) begin
                    state_nxt      = S_IDLE;
                    fault_code_nxt = FC_NONE;
                end
            end
            default: begin
                state_nxt      = S_IDLE;
                fault_code_nxt = FC_NONE;
            end
        endcase
    end

    // State, fault cause and registered start level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fault_code <= FC_NONE;
            start_q    <= 1'b1;
        end else begin
            state      <= state_nxt;
            fault_code <= fault_code_nxt;
            start_q    <= start;
        end
    end

    // Dwell timer: restarts on every state change, counts while the state holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 1'b1;
        end
    end

    // Batch, reject and consecutive-reject bookkeeping, updated in the one-cycle COUNT/REJECT states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_count   <= '0;
            reject_count <= '0;
            rej_run      <= '0;
        end else begin
            case (state)
                S_COUNT: begin
                    rej_run    <= '0;
                    good_count <= last_good ? '0 : good_count + 1'b1;
                end
                S_REJECT: begin
                    rej_run <= rej_run_inc;
                    if (reject_count != '1) reject_count <= reject_count + 1'b1;
                end
                S_FAULT: begin
                    if (state_nxt == S_IDLE) rej_run <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decodes; batch_done uses the pre-increment good count.
    assign motor              = (state == S_MOTOR);
    assign EV                 = (state == S_FILL);
    assign pos_ve             = (state == S_SEAL);
    assign controle_qualidade = (state == S_QC);
    assign count              = (state == S_COUNT);
    assign Desc_signal        = (state == S_REJECT);
    assign idle               = (state == S_IDLE);
    assign fault              = (state == S_FAULT);
    assign batch_done         = (state == S_COUNT) && last_good;

endmodule

// File: tb/tb_bottling_line_ctrl.sv
// Bench for bottling_line_ctrl: directed stimulus with a behavioural model compared every cycle.
// Latency: model advances on the same clk edge as the DUT; compares on the falling edge.
// Backpressure: none; all stimulus is fixed-length, no open-ended waits.
module tb_bottling_line_ctrl;

    localparam int FT    = 4;
    localparam int ST    = 5;
    localparam int BATCH = 3;
    localparam int MAXR  = 2;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, garrafa = 1'b0, sensor_de_nivel = 1'b0, ve_done = 1'b0;
    logic qc_pass = 1'b0, qc_fail = 1'b0, fault_ack = 1'b0;
    logic motor, EV, pos_ve, controle_qualidade, count, Desc_signal, batch_done, idle, fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] good_count, reject_count;

    int tests = 0;
    int fails = 0;

    bottling_line_ctrl #(
        .FILL_TIMEOUT(FT), .SEAL_TIMEOUT(ST), .BATCH_SIZE(BATCH),
        .MAX_REJECTS(MAXR), .CNT_W(CW), .TMR_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .garrafa(garrafa),
        .sensor_de_nivel(sensor_de_nivel), .ve_done(ve_done), .qc_pass(qc_pass),
        .qc_fail(qc_fail), .fault_ack(fault_ack), .motor(motor), .EV(EV),
        .pos_ve(pos_ve), .controle_qualidade(controle_qualidade), .count(count),
        .Desc_signal(Desc_signal), .batch_done(batch_done), .idle(idle),
        .fault(fault), .fault_code(fault_code), .good_count(good_count),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_BELT = 1, P_FILLING = 2, P_SEALING = 3,
                   P_CHECK = 4, P_GOOD = 5, P_BAD = 6, P_STOPPED = 7;

    typedef struct {
        int ph;      // which stage the bottle/line is in
        int dwell;   // cycles spent in this stage, including the current one
        int good;
        int rej;
        int run;
        int code;
        bit prev_start;
    } mstate_t;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.ph = P_IDLE; r.dwell = 1; r.good = 0; r.rej = 0; r.run = 0; r.code = 0;
        r.prev_start = 1'b1;
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t c, logic st, logic g, logic lvl,
                                           logic vd, logic qp, logic qf, logic ack);
        mstate_t n;
        int go;
        n  = c;
        go = c.ph;
        n.prev_start = st;
        if (c.ph == P_IDLE) begin
            if (st && !c.prev_start) go = P_BELT;
        end else if (c.ph == P_STOPPED) begin
            if (ack && !st) begin go = P_IDLE; n.code = 0; n.run = 0; end
        end else if (c.ph == P_GOOD) begin
            n.run = 0;
            if (c.good + 1 == BATCH) begin n.good = 0; go = P_IDLE; end
            else begin n.good = c.good + 1; go = P_BELT; end
        end else if (c.ph == P_BAD) begin
            n.rej = (c.rej == (1 << CW) - 1) ? c.rej : c.rej + 1;
            n.run = c.run + 1;
            if (n.run == MAXR) begin go = P_STOPPED; n.code = 3; end
            else go = P_BELT;
        end else if (!st) begin
            go = P_IDLE;
        end else begin
            if (c.ph == P_BELT && g) go = P_FILLING;
            if (c.ph == P_FILLING) begin
                if (lvl) go = P_SEALING;
                else if (c.dwell == FT) begin go = P_STOPPED; n.code = 1; end
            end
            if (c.ph == P_SEALING) begin
                if (vd) go = P_CHECK;
                else if (c.dwell == ST) begin go = P_STOPPED; n.code = 2; end
            end
            if (c.ph == P_CHECK) begin
                if (qp) go = P_GOOD;
                else if (qf) go = P_BAD;
            end
        end
        n.dwell = (go == c.ph) ? c.dwell + 1 : 1;
        n.ph    = go;
        return n;
    endfunction

    function automatic logic [26:0] model_outputs(mstate_t m);
        logic bd;
        bd = (m.ph == P_GOOD) && (m.good + 1 == BATCH);
        return {m.ph == P_BELT, m.ph == P_FILLING, m.ph == P_SEALING, m.ph == P_CHECK,
                m.ph == P_GOOD, m.ph == P_BAD, bd, m.ph == P_IDLE, m.ph == P_STOPPED,
                2'(m.code), 8'(m.good), 8'(m.rej)};
    endfunction

    mstate_t m = model_reset();

    // Model advances with the DUT and resets with it.
    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_next(m, start, garrafa, sensor_de_nivel, ve_done,
                                   qc_pass, qc_fail, fault_ack);
    end

    logic [26:0] dut_vec;
    assign dut_vec = {motor, EV, pos_ve, controle_qualidade, count, Desc_signal,
                      batch_done, idle, fault, fault_code, good_count, reject_count};

    // Per-cycle compare of every output against the model, away from the active edge.
    always @(negedge clk) begin
        tests++;
        if (dut_vec !== model_outputs(m)) begin
            fails++;
            $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, dut_vec, model_outputs(m));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // From MOTOR: one handshake per stage, ending in COUNT (pass) or REJECT (fail).
    task automatic run_bottle(input bit pass);
        garrafa = 1'b1;         step(1); garrafa = 1'b0;
        sensor_de_nivel = 1'b1; step(1); sensor_de_nivel = 1'b0;
        ve_done = 1'b1;         step(1); ve_done = 1'b0;
        if (pass) qc_pass = 1'b1; else qc_fail = 1'b1;
        step(1);
        qc_pass = 1'b0; qc_fail = 1'b0;
    endtask

    initial begin
        step(2);
        check("rst_idle", 32'(idle), 1);
        check("rst_motor", 32'(motor), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_good", 32'(good_count), 0);
        reset = 1'b0;
        step(2);

        // First bottle through every stage, one cycle each.
        start = 1'b1; step(1);
        check("t1_motor", 32'(motor), 1);
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        check("t1_fill", 32'(EV), 1);
        sensor_de_nivel = 1'b1; step(1); sensor_de_nivel = 1'b0;
        check("t1_seal", 32'(pos_ve), 1);
        ve_done = 1'b1; step(1); ve_done = 1'b0;
        check("t1_qc", 32'(controle_qualidade), 1);
        qc_pass = 1'b1; step(1); qc_pass = 1'b0;
        check("t1_count", 32'(count), 1);
        check("t1_good_pre", 32'(good_count), 0);
        step(1);
        check("t1_motor2", 32'(motor), 1);
        check("t1_count_off", 32'(count), 0);
        check("t1_good", 32'(good_count), 1);

        // Finish the batch of three.
        run_bottle(1'b1); step(1);
        check("t2_good2", 32'(good_count), 2);
        run_bottle(1'b1);
        check("t2_batch_done", 32'(batch_done), 1);
        step(1);
        check("t2_idle", 32'(idle), 1);
        check("t2_good_wrap", 32'(good_count), 0);
        check("t2_batch_off", 32'(batch_done), 0);
        step(3);
        check("t2_still_idle", 32'(idle), 1);
        start = 1'b0; step(1);
        start = 1'b1; step(1);
        check("t2_restart", 32'(motor), 1);

        // Both verdicts at once: counts as good.
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        sensor_de_nivel = 1'b1; step(1); sensor_de_nivel = 1'b0;
        ve_done = 1'b1; step(1); ve_done = 1'b0;
        qc_pass = 1'b1; qc_fail = 1'b1; step(1); qc_pass = 1'b0; qc_fail = 1'b0;
        check("t3_both_count", 32'(count), 1);
        check("t3_both_desc", 32'(Desc_signal), 0);
        step(1);

        // Fill watchdog.
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        step(3);
        check("t4_fill_last", 32'(EV), 1);
        step(1);
        check("t4_fault", 32'(fault), 1);
        check("t4_code", 32'(fault_code), 1);
        fault_ack = 1'b1; step(1);
        check("t4_ack_needs_stop", 32'(fault), 1);
        start = 1'b0; step(1); fault_ack = 1'b0;
        check("t4_idle", 32'(idle), 1);
        check("t4_code_clr", 32'(fault_code), 0);
        check("t4_good_kept", 32'(good_count), 1);

        // Reject run limit, with a good bottle breaking the first run.
        start = 1'b1; step(1);
        run_bottle(1'b0);
        check("t5_desc", 32'(Desc_signal), 1);
        step(1);
        check("t5_rej1", 32'(reject_count), 1);
        run_bottle(1'b1); step(1);
        run_bottle(1'b0); step(1);
        check("t5_no_fault", 32'(motor), 1);
        check("t5_rej2", 32'(reject_count), 2);
        run_bottle(1'b0); step(1);
        check("t5_fault", 32'(fault), 1);
        check("t5_code", 32'(fault_code), 3);
        check("t5_rej3", 32'(reject_count), 3);
        fault_ack = 1'b1; start = 1'b0; step(1); fault_ack = 1'b0;

        // Seal watchdog.
        start = 1'b1; step(1);
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        sensor_de_nivel = 1'b1; step(1); sensor_de_nivel = 1'b0;
        step(4);
        check("t6_seal_last", 32'(pos_ve), 1);
        step(1);
        check("t6_code", 32'(fault_code), 2);
        fault_ack = 1'b1; start = 1'b0; step(1); fault_ack = 1'b0;

        // Level reached on the last allowed fill cycle, then abort during SEAL.
        start = 1'b1; step(1);
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        step(3);
        sensor_de_nivel = 1'b1; step(1); sensor_de_nivel = 1'b0;
        check("t7_late_level", 32'(pos_ve), 1);
        start = 1'b0; step(1);
        check("t7_abort_seal", 32'(pos_ve), 0);
        check("t7_abort_idle", 32'(idle), 1);

        // Asynchronous reset mid-fill, start held through release.
        start = 1'b1; step(1);
        garrafa = 1'b1; step(1); garrafa = 1'b0;
        check("t8_fill", 32'(EV), 1);
        check("t8_good", 32'(good_count), 2);
        reset = 1'b1; #1;
        check("t8_async_idle", 32'(idle), 1);
        check("t8_async_good", 32'(good_count), 0);
        step(2);
        reset = 1'b0;
        step(3);
        check("t8_held_idle", 32'(idle), 1);
        check("t8_held_motor", 32'(motor), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
